// File: rtl/fft_output_streamer_if.sv
// Bundle between the FFT result array, the streamer and the downstream consumer.
// master: the streamer (reads the FFT array, drives the beat stream and status).
// slave : the environment (drives the FFT array/done, consumes beats).
// Optional magnitude output is present when FFT_STREAM_MAG_EN is defined.
interface fft_output_streamer_if #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int DATA_W      = 16
);
  logic [D_WIDTH-1:0][DATA_W-1:0] fft_re;
  logic [D_WIDTH-1:0][DATA_W-1:0] fft_im;
  logic                           fft_done;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_W-1:0]              out_re;
  logic [DATA_W-1:0]              out_im;
  logic [LOG_2_WIDTH-1:0]         out_index;
  logic                           out_last;
  logic                           busy;
  logic                           overrun;
  logic                           clear_overrun;
`ifdef FFT_STREAM_MAG_EN
  logic [DATA_W:0]                out_mag;
`endif

  modport master (
    input  fft_re, fft_im, fft_done, out_ready, clear_overrun,
    output out_valid, out_re, out_im, out_index, out_last, busy, overrun
`ifdef FFT_STREAM_MAG_EN
    , output out_mag
`endif
  );

  modport slave (
    output fft_re, fft_im, fft_done, out_ready, clear_overrun,
    input  out_valid, out_re, out_im, out_index, out_last, busy, overrun
`ifdef FFT_STREAM_MAG_EN
    , input out_mag
`endif
  );
endinterface

// File: rtl/fft_output_streamer.sv
// fft_output_streamer: snapshots the FFT result array on fft_done and streams
// it out one complex bin per beat, index 0 upward, over valid/ready.
// A done pulse landing on the final accepted beat chains straight into the
// next frame; any other done while streaming is dropped and flagged in the
// sticky overrun bit.
// Optional: define FFT_STREAM_MAG_EN to add out_mag = |re| + |im|.
module fft_output_streamer #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int DATA_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_output_streamer_if.master bus
);
  localparam logic [LOG_2_WIDTH-1:0] LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                         state_q, state_d;
  logic [LOG_2_WIDTH-1:0]         idx_q, idx_d;
  logic                           ovr_q, ovr_d;
  logic [D_WIDTH-1:0][DATA_W-1:0] re_q, im_q;
  logic                           capture, ovr_set, xfer, at_last, valid;

  assign valid   = (state_q == STREAM);
  assign xfer    = valid & bus.out_ready;
  assign at_last = (idx_q == LAST_IDX);

  // Next-state: capture, index advance, frame chaining and overrun detection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fft_done) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer && at_last) begin
          // Final beat accepted: either chain a fresh frame or go idle.
          idx_d = '0;
          if (bus.fft_done) capture = 1'b1;
          else              state_d = IDLE;
        end else begin
          if (xfer)         idx_d   = idx_q + 1'b1;
          if (bus.fft_done) ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new drop in the same cycle as a clear must stay visible.
    ovr_d = ovr_set ? 1'b1 : (bus.clear_overrun ? 1'b0 : ovr_q);
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

  // Result buffer: whole-frame snapshot, written only on capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_q <= '0;
      im_q <= '0;
    end else if (capture) begin
      re_q <= bus.fft_re;
      im_q <= bus.fft_im;
    end
  end

  // Beat outputs come straight from registers, so they hold while stalled.
  assign bus.out_valid = valid;
  assign bus.busy      = valid;
  assign bus.out_re    = re_q[idx_q];
  assign bus.out_im    = im_q[idx_q];
  assign bus.out_index = idx_q;
  assign bus.out_last  = valid & at_last;
  assign bus.overrun   = ovr_q;

`ifdef FFT_STREAM_MAG_EN
  logic [DATA_W:0] ext_re, ext_im, abs_re, abs_im;

  // L1 magnitude; one extra bit so |-2**(DATA_W-1)| and the sum never wrap
  always_comb begin
    ext_re = {bus.out_re[DATA_W-1], bus.out_re};
    ext_im = {bus.out_im[DATA_W-1], bus.out_im};
    abs_re = ext_re[DATA_W] ? (~ext_re + 1'b1) : ext_re;
    abs_im = ext_im[DATA_W] ? (~ext_im + 1'b1) : ext_im;
  end

  assign bus.out_mag = abs_re + abs_im;
`endif
endmodule

// File: tb/tb_fft_output_streamer.sv
// Directed bench for fft_output_streamer. Expected beats go into a scoreboard
// queue when a frame is issued; a negedge monitor compares every presented beat
// against the queue head and pops it on transfer.
`timescale 1ns/1ps
module tb_fft_output_streamer;
  localparam int D_WIDTH = 64, LOG_2_WIDTH = 6, DATA_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_output_streamer_if #(.D_WIDTH(D_WIDTH), .LOG_2_WIDTH(LOG_2_WIDTH), .DATA_W(DATA_W)) bus ();

  fft_output_streamer #(.D_WIDTH(D_WIDTH), .LOG_2_WIDTH(LOG_2_WIDTH), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [5:0]  idx;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int vectors = 0;
  int errors  = 0;

  // Frame contents: 0 ramp i/-i, 1 all 0x7FFF, 2 re=100+i im=0, 3 magnitude corners
  function automatic logic [15:0] f_re(input int k, input int i);
    case (k)
      0:       return 16'(i);
      1:       return 16'h7FFF;
      2:       return 16'(100 + i);
      default: return (i == 0) ? 16'h8000 : (i == 1) ? 16'd3 : 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] f_im(input int k, input int i);
    case (k)
      0:       return 16'(-i);
      1:       return 16'h7FFF;
      2:       return 16'd0;
      default: return (i == 0) ? 16'h8000 : (i == 1) ? 16'hFFFC : 16'd0;
    endcase
  endfunction

`ifdef FFT_STREAM_MAG_EN
  function automatic logic [16:0] mag_of(input logic [15:0] r, input logic [15:0] m);
    int a, b;
    a = $signed(r);
    b = $signed(m);
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    return 17'(a + b);
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int k);
    for (int i = 0; i < D_WIDTH; i++) begin
      bus.fft_re[i] = f_re(k, i);
      bus.fft_im[i] = f_im(k, i);
    end
  endtask

  task automatic push_frame(input int k);
    for (int i = 0; i < D_WIDTH; i++)
      sb.push_back('{re: f_re(k, i), im: f_im(k, i), idx: 6'(i), last: (i == D_WIDTH - 1)});
  endtask

  task automatic pulse_done();
    bus.fft_done = 1'b1;
    step();
    bus.fft_done = 1'b0;
  endtask

  task automatic drain(input string name, input int budget, input bit toggle, output int n);
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
      if (toggle) bus.out_ready = ~bus.out_ready;
    end
    if (sb.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL %s_timeout: %0d beats left after %0d cycles", name, sb.size(), n);
      sb.delete();
    end
  endtask

  // Monitor: every valid beat must match the scoreboard head; pop on transfer
  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_beat: idx %0d re %0h with empty scoreboard", bus.out_index, bus.out_re);
      end else begin
        e = sb[0];
        vectors++;
        if ({bus.out_re, bus.out_im, bus.out_index, bus.out_last} !== e) begin
          errors++;
          $display("FAIL beat: got re=%0h im=%0h idx=%0d last=%0b, expected re=%0h im=%0h idx=%0d last=%0b",
                   bus.out_re, bus.out_im, bus.out_index, bus.out_last, e.re, e.im, e.idx, e.last);
        end
`ifdef FFT_STREAM_MAG_EN
        check("beat_mag", 32'(bus.out_mag), 32'(mag_of(e.re, e.im)));
`endif
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.fft_done      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.clear_overrun = 1'b0;
    load_frame(1);
    // Leave stale data on the FFT array to show reset ignores it.

    // 1: reset for 3 cycles, then idle with no done
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("idle_valid", bus.out_valid, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_overrun", bus.overrun, 0);
      check("idle_index", bus.out_index, 0);
      check("idle_last", bus.out_last, 0);
      check("idle_re", bus.out_re, 0);
      check("idle_im", bus.out_im, 0);
    end

    // 2: ramp frame at full throughput
    load_frame(0);
    bus.out_ready = 1'b1;
    push_frame(0);
    pulse_done();
    check("t2_first_valid", bus.out_valid, 1);
    check("t2_first_index", bus.out_index, 0);
    check("t2_busy", bus.busy, 1);
    drain("t2", 200, 1'b0, n);
    check("t2_cycles", n, 64);
    check("t2_valid_after", bus.out_valid, 0);
    check("t2_last_after", bus.out_last, 0);

    // 3: same frame with ready toggling 1,0,1,0
    push_frame(0);
    pulse_done();
    drain("t3", 300, 1'b1, n);
    check("t3_within_128", (n <= 128), 1);
    check("t3_valid_after", bus.out_valid, 0);
    bus.out_ready = 1'b1;

    // 4: dropped frame after beat 10, set-vs-clear priority, then clear
    push_frame(0);
    pulse_done();
    repeat (11) step();
    check("t4_index11", bus.out_index, 11);
    load_frame(1);
    pulse_done();
    check("t4_overrun_set", bus.overrun, 1);
    check("t4_index_after_drop", bus.out_index, 12);
    bus.clear_overrun = 1'b1;
    pulse_done();
    bus.clear_overrun = 1'b0;
    check("t4_set_wins", bus.overrun, 1);
    drain("t4", 200, 1'b0, n);
    check("t4_busy_after", bus.busy, 0);
    check("t4_overrun_held", bus.overrun, 1);
    bus.clear_overrun = 1'b1;
    step();
    bus.clear_overrun = 1'b0;
    check("t4_overrun_cleared", bus.overrun, 0);

    // 5: next frame's done coincides with beat 63 transfer
    load_frame(0);
    push_frame(0);
    pulse_done();
    n = 0;
    while (bus.out_index != 6'd63 && n < 100) begin
      step();
      n++;
    end
    check("t5_reach_63", bus.out_index, 63);
    load_frame(2);
    push_frame(2);
    pulse_done();
    check("t5_no_gap_valid", bus.out_valid, 1);
    check("t5_index0", bus.out_index, 0);
    check("t5_re100", bus.out_re, 100);
    check("t5_no_overrun", bus.overrun, 0);
    drain("t5", 200, 1'b0, n);
    check("t5_cycles", n, 64);
    check("t5_valid_after", bus.out_valid, 0);

    // 6: reset mid-stream at beat 20; done during reset is ignored
    load_frame(0);
    push_frame(0);
    pulse_done();
    repeat (20) step();
    check("t6_index20", bus.out_index, 20);
    rst = 1'b1;
    #1;
    check("t6_abort_valid", bus.out_valid, 0);
    check("t6_abort_index", bus.out_index, 0);
    check("t6_abort_busy", bus.busy, 0);
    check("t6_abort_re", bus.out_re, 0);
    check("t6_abort_im", bus.out_im, 0);
    sb.delete();
    pulse_done();
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t6_idle_valid", bus.out_valid, 0);
      check("t6_idle_re", bus.out_re, 0);
    end

`ifdef FFT_STREAM_MAG_EN
    // 7: magnitude corner cases
    load_frame(3);
    push_frame(3);
    bus.out_ready = 1'b0;
    pulse_done();
    check("t7_mag_min", 32'(bus.out_mag), 65536);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t7_mag_3_m4", 32'(bus.out_mag), 7);
    bus.out_ready = 1'b1;
    drain("t7", 200, 1'b0, n);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fft_output_streamer.md
Name: fft_output_streamer

Overview:
Reader side of the FFT result interface. On the FFT's one-cycle `done` pulse it snapshots the full D_WIDTH-entry complex result array into a local buffer. It then streams the entries out one per beat, in natural index order, over a valid/ready handshake. This frees the FFT to start a new frame while results drain to the downstream consumer.

Parameters:
D_WIDTH, 64, number of complex points per frame
LOG_2_WIDTH, 6, index width; D_WIDTH = 2**LOG_2_WIDTH
DATA_W, 16, width of each real/imag sample (two's complement)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
fft_re  in  DATA_W x D_WIDTH  FFT real result array
fft_im  in  DATA_W x D_WIDTH  FFT imag result array
fft_done  in  1  one-cycle pulse: result array valid this cycle
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_re  out  DATA_W  real part of current beat
out_im  out  DATA_W  imag part of current beat
out_index  out  LOG_2_WIDTH  bin index of current beat
out_last  out  1  high with final beat of frame (index D_WIDTH-1)
busy  out  1  frame held / streaming in progress
overrun  out  1  sticky: a fft_done was dropped
clear_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - out_valid=0, out_index=0, out_last=0, busy=0, overrun=0.
  - Buffer zeroed, so out_re=0 and out_im=0.
- States: IDLE, STREAM.
- IDLE + fft_done=1:
  - Capture all D_WIDTH re/im entries on that edge.
  - index <= 0, go to STREAM.
  - Latency: out_valid=1 in the cycle after the fft_done cycle.
- STREAM:
  - out_valid=1, busy=1.
  - out_re/out_im = buffer[index]; out_index = index.
  - out_last = (index == D_WIDTH-1).
- Handshake:
  - A beat transfers when out_valid & out_ready.
  - While out_valid & ~out_ready, out_re, out_im, out_index and out_last are held stable.
  - On transfer with index < D_WIDTH-1: index increments.
  - On transfer with index = D_WIDTH-1: go to IDLE, out_valid=0, index=0.
- Throughput: D_WIDTH cycles per frame with out_ready held high.
- fft_done in STREAM, not on the final transfer:
  - Frame is dropped.
  - Buffer and index are unchanged.
  - overrun <= 1.
- fft_done coincident with the final transfer (index D_WIDTH-1 accepted):
  - New frame is captured.
  - Stay in STREAM with index=0; no idle bubble, no overrun.
- overrun clearing:
  - Cleared by clear_overrun=1.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-stream:
  - Immediate abort: out_valid drops asynchronously and the buffer is cleared.
  - fft_done pulses arriving while rst=1 are ignored.
- The buffer is written only on capture; no partial updates.

Optional Feature:
Macro FFT_STREAM_MAG_EN.
- Defined:
  - Adds output out_mag, width DATA_W+1, unsigned.
  - out_mag = |out_re| + |out_im|, combinational from the current beat, no saturation.
  - |−2**(DATA_W-1)| = 2**(DATA_W-1).
  - Valid under the same handshake as out_re.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
1. Assert rst for 3 cycles, release, no fft_done -> out_valid=0, busy=0, overrun=0, out_index=0, out_re=out_im=0 throughout.
2. Frame fft_re[i]=i, fft_im[i]=-i, out_ready=1, then pulse fft_done -> 64 consecutive beats with index 0..63, out_re=i, out_im=-i, out_last only on index 63, out_valid=0 the cycle after.
3. Same frame, out_ready toggling 1,0,1,0 -> data stable during ready=0; 64 transfers complete in 128 cycles; order and values unchanged.
4. Second fft_done (all entries 0x7FFF) after beat 10 -> overrun=1; beats 11..63 still carry the first frame's values. Pulse clear_overrun -> overrun=0 next cycle.
5. Second frame (re[i]=100+i) with fft_done on the same cycle as beat 63's transfer -> next cycle out_valid=1, index 0, out_re=100, no gap, overrun=0.
6. Assert rst mid-stream at beat 20 -> out_valid=0 immediately, out_index=0. After release, IDLE until the next fft_done.
7. With FFT_STREAM_MAG_EN: re=-32768, im=-32768 gives out_mag=65536; re=3, im=-4 gives out_mag=7.
